// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment display path.
package display_pkg;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned WORD_W     = NUM_DIGITS * DIGIT_W;

  localparam logic [NUM_DIGITS-1:0] BLANK_ANODES = 4'b1111;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [SEL_W-1:0]   sel_t;

  // Nibble n of a packed display word; digit 0 is the rightmost nibble.
  function automatic digit_t digit_at(input logic [WORD_W-1:0] word, input sel_t sel);
    return word[sel*DIGIT_W +: DIGIT_W];
  endfunction
endpackage

// File: rtl/display_scan_mux_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks (DIV >= 2).
// Shared by the display scanner and the alarm blink/beep logic.
module tick_gen #(
  parameter int unsigned DIV = 100_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign tick_o = (cnt_reg == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (tick_o) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
endmodule

// File: rtl/display_scan_mux.sv
// Four-digit seven-segment scanner with tear-free shadow update at frame boundaries.
// Optional per-digit blinking is built when DISP_BLINK_EN is defined.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int unsigned DIV          = 100_000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_W-1:0]     digits_i,
  input  logic                  upd_req_i,
  output logic                  upd_ack_o,
  input  logic [NUM_DIGITS-1:0] blank_mask_i,
`ifdef DISP_BLINK_EN
  input  logic [NUM_DIGITS-1:0] blink_mask_i,
`endif
  output logic [SEL_W-1:0]      sel_o,
  output logic [DIGIT_W-1:0]    digit_o,
  output logic                  blank_o,
  output logic                  frame_o
);
  if (DIV < 2 || BLINK_FRAMES < 1) begin : g_param_check
    $error("display_scan_mux: DIV must be >= 2 and BLINK_FRAMES >= 1");
  end

  logic              tick;
  logic              boundary;
  logic              apply;
  sel_t              sel_next;
  logic [WORD_W-1:0] staging_reg;
  logic [WORD_W-1:0] shadow_reg;
  logic [WORD_W-1:0] shadow_next;
  logic              pending_reg;
  logic              blank_next;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  assign sel_next = sel_o + SEL_W'(1);
  assign boundary = tick & (sel_o == SEL_W'(NUM_DIGITS - 1));
  // A request landing on the boundary cycle bypasses staging so slot 0 shows it at once.
  assign apply    = boundary & (pending_reg | upd_req_i);

  always_comb begin
    shadow_next = shadow_reg;
    if (apply) begin
      shadow_next = upd_req_i ? digits_i : staging_reg;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int unsigned BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BF_W-1:0] blink_cnt_reg;
  logic            blink_phase_reg;
  logic            blink_phase_next;
  logic            blink_wrap;

  assign blink_wrap = (blink_cnt_reg == BF_W'(BLINK_FRAMES - 1));

  always_comb begin
    blink_phase_next = blink_phase_reg;
    if (boundary && blink_wrap) begin
      blink_phase_next = ~blink_phase_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (boundary) begin
      blink_cnt_reg   <= blink_wrap ? '0 : blink_cnt_reg + 1'b1;
      blink_phase_reg <= blink_phase_next;
    end
  end

  // Phase is taken post-toggle so a whole frame shares the same blink state.
  assign blank_next = blank_mask_i[sel_next] | (blink_mask_i[sel_next] & blink_phase_next);
`else
  assign blank_next = blank_mask_i[sel_next];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging_reg <= '0;
      shadow_reg  <= '0;
      pending_reg <= 1'b0;
      upd_ack_o   <= 1'b0;
      frame_o     <= 1'b0;
      sel_o       <= '0;
      digit_o     <= '0;
      blank_o     <= 1'b0;
    end else begin
      upd_ack_o  <= apply;
      frame_o    <= boundary;
      shadow_reg <= shadow_next;
      if (upd_req_i) begin
        staging_reg <= digits_i;
      end
      if (boundary) begin
        pending_reg <= 1'b0;
      end else if (upd_req_i) begin
        pending_reg <= 1'b1;
      end
      if (tick) begin
        sel_o   <= sel_next;
        digit_o <= digit_at(shadow_next, sel_next);
        blank_o <= blank_next;
      end
    end
  end
endmodule
